axi4_mem_slave: RTL
===================

// Module: axi4_mem_slave
// PURPOSE
//  AXI4 responder (slave) end of the AXI4ReadChannel/AXI4WriteChannel pair; counterpart of AXIMaster.
//  Word-addressed on-chip memory of DEPTH 32-bit words at ADDR_BASE, serving reads and writes.
//  Independent read and write FSMs; bursts of 1-2 beats, INCR by 4; adds B (write response) channel.
// PARAMETERS
//  DEPTH      256           number of 32-bit words (power of 2, >=2)
//  ADDR_BASE  32'h0000_0000 byte address of word 0; must be DEPTH*4 aligned
// PORTS
//  aclk     in   1   clock; all logic on rising edge
//  areset   in   1   synchronous, active-high reset
//  arvalid  in   1   / arready out 1 : read address handshake
//  araddr   in   32  read start byte address ([1:0] ignored)
//  arlen    in   1   beats-1 (0: 1 beat, 1: 2 beats)
//  arsize   in   1   1: 4-byte beats; 0: unsupported -> SLVERR
//  rvalid   out  1   / rready in 1 : read data handshake
//  rdata    out  32  read data
//  rresp    out  32  [1:0] response (00 OKAY,10 SLVERR,11 DECERR); [31:2] always 0
//  awvalid  in   1   / awready out 1 : write address handshake
//  awaddr   in   32  write start byte address ([1:0] ignored)
//  awlen    in   1   beats-1; awsize in 1 : as arsize
//  wvalid   in   1   / wready out 1 : write data handshake
//  wdata    in   32  write data; wstrb in 4 : byte enables, bit i -> wdata[8i+7:8i]
//  bvalid   out  1   / bready in 1 : write response handshake
//  bresp    out  2   write response, encoding as rresp[1:0]
// BEHAVIOUR
//  Reset (areset=1 at edge): both FSMs -> IDLE; arready,awready,wready,rvalid,bvalid=0 while areset high;
//   rdata=0, rresp=0, bresp=0. Memory contents retained. Reset mid-burst aborts it, no response issued.
//  Beat address: a_k = start&~3 + 4k. In range iff ADDR_BASE <= a_k < ADDR_BASE+4*DEPTH; index (a_k-ADDR_BASE)>>2.
//  Read FSM R_IDLE -> R_DATA -> R_IDLE:
//   R_IDLE: arready=1. arvalid&arready at edge N: capture len/size/addr, read beat 0; rvalid=1 from N+1.
//   R_DATA: rdata/rresp stable while rvalid&!rready. rvalid&rready on a non-last beat: next beat loaded
//    same edge, rvalid stays 1 (zero-bubble). On last beat: rvalid=0, -> R_IDLE (arready=1 next cycle).
//   Per beat: size=0 -> rresp SLVERR, rdata 0; out of range -> DECERR, rdata 0; else OKAY, mem word.
//   Min read turnaround: AR at N, R at N+1, next AR accepted N+2.
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   W_IDLE: awready=1, wready=0. AW handshake: capture, -> W_DATA; W before AW is not accepted.
//   W_DATA: wready=1. Each wvalid&wready: if size=1 and in range, write bytes with wstrb set; addr+=4.
//    Error beats write nothing. After beat awlen+1 -> W_RESP (wready=0).
//   W_RESP: bvalid=1, bresp = SLVERR if size=0, else DECERR if any beat out of range, else OKAY.
//    bvalid,bresp held until bready; bvalid&bready -> W_IDLE, awready=1 next cycle.
//  Read/write same word same edge: read returns pre-write data (write visible from next read).
//  Second beat past top of range -> that beat DECERR; address never wraps within memory.
//  Read and write FSMs run concurrently; no ordering enforced between channels.
// TESTING
//  1. Reset then idle: areset 2 cycles -> arready=awready=1, wready=rvalid=bvalid=0, rdata=0 after release.
//  2. AW 0x10 len0 size1; W 0xDEADBEEF strb F -> bvalid, bresp 00; AR 0x10 -> rdata 0xDEADBEEF, rresp 0.
//  3. Byte strobe: write 0x11223344 strb 0101 over 0xDEADBEEF at 0x20 -> readback 0xDE22BE44.
//  4. Read burst len1 at 0x10 with rready low 3 cycles on beat 0 -> rdata stable, then beats mem[4],mem[5]
//     back-to-back, rvalid drops after beat 1, arready=1 following cycle.
//  5. Errors: AR at ADDR_BASE+4*DEPTH-4 len1 -> beat0 OKAY, beat1 DECERR rdata 0; AW size0 -> SLVERR, mem unchanged.
//  6. areset asserted during W_DATA after beat 0 of len1 -> no bvalid; beat 0 data kept; next AW accepted.

Source files
------------

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 responder over a word-addressed on-chip memory, 1-2 beat INCR bursts
module axi4_mem_slave #(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   input  logic        arlen,
   input  logic        arsize,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [31:0] rresp,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] awaddr,
   input  logic        awlen,
   input  logic        awsize,
   input  logic        wvalid,
   output logic        wready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [32:0] LO = {1'b0, ADDR_BASE};
   localparam logic [32:0] HI = LO + 33'(4 * DEPTH);

   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [31:0] mem [DEPTH];

   // Addresses carry a 33rd bit so a burst stepping past 0xFFFF_FFFC never wraps back into range.
   function automatic logic in_rng(input logic [32:0] a);
      return a >= LO && a < HI;
   endfunction

   function automatic logic [AW-1:0] idx(input logic [32:0] a);
      return AW'((a - LO) >> 2);
   endfunction

   r_state_t    r_state, r_next;
   logic [31:0] r_addr;
   logic        r_size, r_left, r_load, rb_size, rb_ok;
   logic [1:0]  r_resp;
   logic [32:0] rb_addr;

   // Read beat selection: beat 0 comes from AR, later beats step the held address.
   always_comb begin
      rb_addr = (r_state == R_IDLE) ? {1'b0, araddr[31:2], 2'b00} : {1'b0, r_addr} + 33'd4;
      rb_size = (r_state == R_IDLE) ? arsize : r_size;
      rb_ok   = rb_size && in_rng(rb_addr);
      r_load  = (r_state == R_IDLE) ? arvalid : rready && r_left;
      r_next  = (r_state == R_IDLE) ? (arvalid ? R_DATA : R_IDLE)
                                    : (rready && !r_left ? R_IDLE : R_DATA);
   end

   // Read state register.
   always_ff @(posedge aclk)
      r_state <= areset ? R_IDLE : r_next;

   // Read beat registers; rdata/rresp only change when a new beat is loaded.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_addr <= '0;
         r_size <= 1'b0;
         r_left <= 1'b0;
         rdata  <= '0;
         r_resp <= 2'b00;
      end else if (r_load) begin
         r_addr <= rb_addr[31:0];
         r_size <= rb_size;
         r_left <= (r_state == R_IDLE) && arlen;
         rdata  <= rb_ok ? mem[idx(rb_addr)] : 32'd0;
         r_resp <= !rb_size ? 2'b10 : rb_ok ? 2'b00 : 2'b11;
      end
   end

   assign arready = r_state == R_IDLE && !areset;
   assign rvalid  = r_state == R_DATA && !areset;
   assign rresp   = {30'd0, r_resp};

   w_state_t    w_state, w_next;
   logic [32:0] w_addr;
   logic        w_size, w_left, w_err, w_beat, w_ok;
   logic [1:0]  b_resp;

   // Write next-state and beat qualification.
   always_comb begin
      w_beat = wready && wvalid;
      w_ok   = w_size && in_rng(w_addr);
      w_next = (w_state == W_IDLE) ? (awvalid ? W_DATA : W_IDLE)
             : (w_state == W_DATA) ? (wvalid && !w_left ? W_RESP : W_DATA)
             : (bready ? W_IDLE : W_RESP);
   end

   // Write state register.
   always_ff @(posedge aclk)
      w_state <= areset ? W_IDLE : w_next;

   // Write burst tracking; the response is settled when the last beat lands.
   always_ff @(posedge aclk) begin
      if (areset) begin
         w_addr <= '0;
         w_size <= 1'b0;
         w_left <= 1'b0;
         w_err  <= 1'b0;
         b_resp <= 2'b00;
      end else if (w_state == W_IDLE && awvalid) begin
         w_addr <= {1'b0, awaddr[31:2], 2'b00};
         w_size <= awsize;
         w_left <= awlen;
         w_err  <= 1'b0;
      end else if (w_beat) begin
         w_addr <= w_addr + 33'd4;
         w_left <= 1'b0;
         w_err  <= w_err || !in_rng(w_addr);
         if (!w_left)
            b_resp <= !w_size ? 2'b10 : (w_err || !in_rng(w_addr)) ? 2'b11 : 2'b00;
      end
   end

   // Byte-enabled memory write; contents survive reset.
   always_ff @(posedge aclk)
      for (int i = 0; i < 4; i++)
         if (w_beat && w_ok && wstrb[i])
            mem[idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];

   assign awready = w_state == W_IDLE && !areset;
   assign wready  = w_state == W_DATA && !areset;
   assign bvalid  = w_state == W_RESP && !areset;
   assign bresp   = b_resp;

   logic unused_bits;
   assign unused_bits = ^{araddr[1:0], awaddr[1:0]};
endmodule
